// File: rtl/apb_regbank_slave.sv
// APB4 completer in front of a DEPTH x 32-bit register bank with byte strobes,
// a fixed number of wait states and a registered error response.
module apb_regbank_slave #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          PROT_START  = DEPTH / 2
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [2:0]  pprot,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        pready
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [31:0] PROT_IDX = 32'(PROT_START);

    // Handshake: a transfer starts on a setup edge (psel=1, penable=0) seen in IDLE;
    // pready is high for exactly one cycle (DONE), dropping psel in WAIT aborts it.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  lat_idx;
    logic           lat_write;
    logic           lat_err;
    logic [31:0]    mem [DEPTH];

    logic           setup;
    logic [31:0]    offset;
    logic [AW-1:0]  setup_idx;
    logic           setup_err;
    logic           enter_done;
    logic [AW-1:0]  acc_idx;
    logic           acc_err;
    logic           acc_write;
    logic           unused_prot;

    assign setup       = psel & ~penable;
    assign offset      = paddr - BASE_ADDR;
    assign setup_idx   = offset[AW+1:2];
    assign setup_err   = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (offset >= SPAN) ||
                         (({{(32-AW){1'b0}}, setup_idx} >= PROT_IDX) && !pprot[0]);
    assign unused_prot = ^pprot[2:1];

    always_ff @(posedge pclk) begin
        if (!preset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (setup) state_d = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: begin
                if (!psel)                            state_d = IDLE;
                else if (penable && cnt_q == 4'd1)    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready = (state_q == DONE);
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            cnt_q     <= 4'd0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
        end else if (state_q == IDLE && setup) begin
            cnt_q     <= 4'(WAIT_STATES);
            lat_idx   <= setup_idx;
            lat_write <= pwrite;
            lat_err   <= setup_err;
        end else if (state_q == WAIT && psel && penable && cnt_q != 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // With zero wait states DONE is entered straight from the setup edge,
    // so the read path takes the live decode instead of the latched one.
    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign acc_idx    = (state_q == IDLE) ? setup_idx : lat_idx;
    assign acc_err    = (state_q == IDLE) ? setup_err : lat_err;
    assign acc_write  = (state_q == IDLE) ? pwrite    : lat_write;

    always_ff @(posedge pclk) begin
        if (!preset) begin
            prdata  <= 32'd0;
            pslverr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            prdata  <= 32'd0;
            pslverr <= 1'b0;
            if (enter_done) begin
                if (acc_err)         pslverr <= 1'b1;
                else if (!acc_write) prdata  <= mem[acc_idx];
            end
            if (state_q == DONE && lat_write && !lat_err) begin
                for (int n = 0; n < 4; n++)
                    if (pstrb[n]) mem[lat_idx][8*n +: 8] <= pwdata[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: four instances with different wait states and
// base addresses, directed vectors, hand sequences and a random model check.
module tb_apb_regbank_slave;

    localparam int          N   = 4;
    localparam int          DEP = 16;
    localparam int          WS_T   [N] = '{1, 0, 3, 15};
    localparam logic [31:0] BASE_T [N] = '{32'h0000_0000, 32'h0000_0400, 32'h0000_1000, 32'h0000_0000};
    localparam int          PROT_T [N] = '{8, 16, 8, 8};

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel    [N];
    logic        penable [N];
    logic [31:0] paddr   [N];
    logic        pwrite  [N];
    logic [2:0]  pprot   [N];
    logic [31:0] pwdata  [N];
    logic [3:0]  pstrb   [N];
    logic [31:0] prdata  [N];
    logic        pslverr [N];
    logic        pready  [N];

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_regbank_slave #(
            .DEPTH(DEP), .BASE_ADDR(BASE_T[g]), .WAIT_STATES(WS_T[g]), .PROT_START(PROT_T[g])
        ) u_dut (
            .pclk(pclk), .preset(preset), .psel(psel[g]), .penable(penable[g]),
            .paddr(paddr[g]), .pwrite(pwrite[g]), .pprot(pprot[g]), .pwdata(pwdata[g]),
            .pstrb(pstrb[g]), .prdata(prdata[g]), .pslverr(pslverr[g]), .pready(pready[g])
        );
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [N][DEP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address rules evaluated on plain integers, independent of the RTL decode.
    function automatic bit model_err(input int d, input logic [31:0] a, input logic [2:0] prot);
        longint off;
        off = longint'(a) - longint'(BASE_T[d]);
        if (a % 4 != 0) return 1'b1;
        if (off < 0 || off >= DEP * 4) return 1'b1;
        if (off / 4 >= PROT_T[d] && !prot[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_idx(input int d, input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE_T[d])) / 4);
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        int idx;
        idx = model_idx(d, a);
        for (int n = 0; n < 4; n++)
            if (st[n]) model_mem[d][idx][8*n +: 8] = wd[8*n +: 8];
    endtask

    task automatic model_clear();
        for (int d = 0; d < N; d++)
            for (int i = 0; i < DEP; i++) model_mem[d][i] = 32'd0;
    endtask

    task automatic idle_bus(input int d);
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 32'd0;
        pwdata[d] = 32'd0; pstrb[d] = 4'd0; pprot[d] = 3'd0;
    endtask

    // Called #1 after a rising edge; drives setup immediately so calls chain back to back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic er, output int done_cyc);
        int lat;
        bit quiet;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
        pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        lat = 1;
        quiet = 1'b1;
        while (pready[d] !== 1'b1 && lat <= 20) begin
            if (prdata[d] !== 32'd0 || pslverr[d] !== 1'b0) quiet = 1'b0;
            @(posedge pclk); #1;
            lat++;
        end
        check($sformatf("latency d%0d a=%h", d, a), 32'(lat), 32'(WS_T[d] + 1));
        check($sformatf("quiet d%0d a=%h", d, a), {31'd0, quiet}, 32'd1);
        rd = prdata[d];
        er = pslverr[d];
        done_cyc = cyc;
        @(posedge pclk); #1;
        idle_bus(d);
    endtask

    task automatic do_op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input string name);
        logic [31:0] rd;
        logic        er;
        bit          exp_e;
        int          c;
        exp_e = model_err(d, a, pr);
        xfer(d, wr, a, wd, st, pr, rd, er, c);
        check({name, " err"}, {31'd0, er}, {31'd0, exp_e});
        if (!wr) check({name, " rdata"}, rd, exp_e ? 32'd0 : model_mem[d][model_idx(d, a)]);
        if (wr && !exp_e) model_write(d, a, wd, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [17];
        logic [31:0] rd;
        logic        er;
        int          c1, c2;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'hF, 3'b000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h04, 32'h11223344, 4'h5, 3'b000, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hDE22BE44, 1'b0};
        vecs[6]  = '{1'b0, 32'h02, 32'h0,        4'h0, 3'b001, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 3'b001, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h20, 32'h0,        4'h0, 3'b000, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h20, 32'h0,        4'h0, 3'b001, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b1, 32'h20, 32'h12345678, 4'hF, 3'b000, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'h20, 32'h0,        4'h0, 3'b001, 32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'h0, 3'b001, 32'h0, 1'b0};
        vecs[14] = '{1'b1, 32'h3C, 32'h89ABCDEF, 4'hA, 3'b001, 32'h0, 1'b0};
        vecs[15] = '{1'b0, 32'h3C, 32'h0,        4'h0, 3'b001, 32'h8900CD00, 1'b0};
        vecs[16] = '{1'b0, 32'h1C, 32'h0,        4'h0, 3'b000, 32'h0, 1'b0};

        // Reset with psel held high: outputs must stay quiet.
        for (int d = 0; d < N; d++) begin
            idle_bus(d);
            psel[d] = 1'b1;
        end
        preset = 1'b0;
        model_clear();
        repeat (2) begin
            @(posedge pclk); #1;
            for (int d = 0; d < N; d++)
                check($sformatf("reset outs d%0d", d), {prdata[d][29:0], pslverr[d], pready[d]}, 32'd0);
        end
        preset = 1'b1;
        for (int d = 0; d < N; d++) idle_bus(d);
        @(posedge pclk); #1;

        for (int i = 0; i < DEP; i++)
            do_op(0, 1'b0, BASE_T[0] + 32'(4 * i), 32'd0, 4'd0, 3'b001, $sformatf("post-reset word%0d", i));

        for (int i = 0; i < 17; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, rd, er, c1);
            check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            if (vecs[i].wr && !vecs[i].exp_err) model_write(0, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        end

        // Abort: psel dropped in the first wait cycle of a write.
        do_op(0, 1'b1, 32'h0C, 32'hA5A5A5A5, 4'hF, 3'b000, "abort prefill");
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0C;
        pwdata[0] = 32'h5A5A5A5A; pstrb[0] = 4'hF; pprot[0] = 3'b000;
        @(posedge pclk); #1;
        check("abort T1 pready", {31'd0, pready[0]}, 32'd0);
        idle_bus(0);
        repeat (3) begin
            @(posedge pclk); #1;
            check("abort idle pready", {31'd0, pready[0]}, 32'd0);
        end
        do_op(0, 1'b0, 32'h0C, 32'd0, 4'd0, 3'b000, "abort readback");

        // Back-to-back reads on every instance: period is WAIT_STATES+2.
        for (int d = 0; d < N; d++) begin
            xfer(d, 1'b0, BASE_T[d], 32'd0, 4'd0, 3'b001, rd, er, c1);
            xfer(d, 1'b0, BASE_T[d] + 32'd4, 32'd0, 4'd0, 3'b001, rd, er, c2);
            check($sformatf("b2b period d%0d", d), 32'(c2 - c1), 32'(WS_T[d] + 2));
        end

        // Random traffic against the reference model.
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < 30; k++) begin
                int          off;
                logic [31:0] a;
                off = int'($urandom_range(0, DEP * 4 + 15)) - 8;
                if ($urandom_range(0, 3) != 0) off = off & ~3;
                a = BASE_T[d] + 32'(off);
                do_op(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), $sformatf("rand d%0d k%0d a=%h", d, k, a));
            end
        end

        // Reset asserted while a write sits in DONE: the write is dropped.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h14;
        pwdata[0] = 32'h77777777; pstrb[0] = 4'hF; pprot[0] = 3'b001;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        @(posedge pclk); #1;
        check("rst-done pready", {31'd0, pready[0]}, 32'd1);
        preset = 1'b0;
        @(posedge pclk); #1;
        check("rst-done outs", {prdata[0][29:0], pslverr[0], pready[0]}, 32'd0);
        check("rst-done prdata", prdata[0], 32'd0);
        idle_bus(0);
        preset = 1'b1;
        model_clear();
        do_op(0, 1'b0, 32'h14, 32'd0, 4'd0, 3'b001, "rst-done word5");
        do_op(0, 1'b0, 32'h04, 32'd0, 4'd0, 3'b001, "rst-done word1");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
